// File: rtl/tour_cmd_pkg.sv
// Shared types and constants for the knight-tour command sequencer.
package tour_cmd_pkg;

  typedef enum logic [2:0] {IDLE, VERT, WAIT_V, HORZ, WAIT_H} state_e;

  localparam logic [3:0] MOVE    = 4'h2;
  localparam logic [3:0] MOVE_FF = 4'h3;

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;

  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_POS = 8'h5A;

  localparam logic [4:0] LAST_MV = 5'd23;

  typedef struct packed {
    logic [7:0] leg1;
    logic [7:0] leg2;
  } legs_t;

endpackage

// File: rtl/tour_cmd_if.sv
// Command/response bundle between UART wrapper, tour logic, cmd_proc and tour_cmd.
interface tour_cmd_if;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic [7:0]  resp;

  modport master (
    input  start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    output mv_indx, cmd, cmd_rdy, resp
  );

  modport slave (
    output start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    input  mv_indx, cmd, cmd_rdy, resp
  );
endinterface

// File: rtl/tour_move_dec.sv
// One-hot knight move to {2-square heading, 1-square heading}; lowest set bit wins.
module tour_move_dec
  import tour_cmd_pkg::*;
(
  input  logic [7:0] move_i,
  output legs_t      legs_o
);

  always_comb begin
    legs_o = '{leg1: HDG_N, leg2: HDG_E};
    casez (move_i)
      8'b???????1: legs_o = '{leg1: HDG_N, leg2: HDG_E};
      8'b??????10: legs_o = '{leg1: HDG_N, leg2: HDG_W};
      8'b?????100: legs_o = '{leg1: HDG_W, leg2: HDG_N};
      8'b????1000: legs_o = '{leg1: HDG_W, leg2: HDG_S};
      8'b???10000: legs_o = '{leg1: HDG_S, leg2: HDG_W};
      8'b??100000: legs_o = '{leg1: HDG_S, leg2: HDG_E};
      8'b?1000000: legs_o = '{leg1: HDG_E, leg2: HDG_S};
      8'b10000000: legs_o = '{leg1: HDG_E, leg2: HDG_N};
      default:     legs_o = '{leg1: HDG_N, leg2: HDG_E};
    endcase
  end

endmodule

// File: rtl/tour_cmd.sv
// Muxes UART commands to cmd_proc when idle; during a tour issues two leg
// commands per knight move and steps mv_indx through 0..LAST_MV.
module tour_cmd
  import tour_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  tour_cmd_if.master bus
);

  state_e      state_q, state_d;
  logic [4:0]  mv_q, mv_d;
  logic [7:0]  move_q, move_d;
  logic [15:0] cmd_q, cmd_d;
  logic        rdy_q, rdy_d;
  logic        entry_q, entry_d;
  logic [7:0]  mv_sel;
  legs_t       legs;

  // Move is sampled in the first VERT cycle, after mv_indx has settled,
  // so the tour logic has already presented the move for the new index.
  assign mv_sel = (state_q == VERT && entry_q) ? bus.move : move_q;

  tour_move_dec u_dec (
    .move_i (mv_sel),
    .legs_o (legs)
  );

  always_comb begin
    state_d = state_q;
    mv_d    = mv_q;
    move_d  = move_q;
    cmd_d   = cmd_q;
    rdy_d   = 1'b0;
    entry_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_tour) begin
          mv_d    = 5'd0;
          state_d = VERT;
          entry_d = 1'b1;
        end
      end
      VERT: begin
        if (entry_q) move_d = bus.move;
        if (mv_sel == 8'h00) begin
          state_d = IDLE;
        end else if (bus.clr_cmd_rdy) begin
          state_d = WAIT_V;
        end else begin
          rdy_d = 1'b1;
          cmd_d = {MOVE, legs.leg1, 4'h2};
        end
      end
      WAIT_V: begin
        if (bus.send_resp) state_d = HORZ;
      end
      HORZ: begin
        if (bus.clr_cmd_rdy) begin
          state_d = WAIT_H;
        end else begin
          rdy_d = 1'b1;
          cmd_d = {MOVE_FF, legs.leg2, 4'h1};
        end
      end
      WAIT_H: begin
        if (bus.send_resp) begin
          if (mv_q == LAST_MV) begin
            state_d = IDLE;
          end else begin
            mv_d    = mv_q + 5'd1;
            state_d = VERT;
            entry_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mv_q    <= 5'd0;
      move_q  <= 8'h00;
      cmd_q   <= 16'h0000;
      rdy_q   <= 1'b0;
      entry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mv_q    <= mv_d;
      move_q  <= move_d;
      cmd_q   <= cmd_d;
      rdy_q   <= rdy_d;
      entry_q <= entry_d;
    end
  end

  always_comb begin
    bus.mv_indx = mv_q;
    if (state_q == IDLE) begin
      bus.cmd     = bus.cmd_UART;
      bus.cmd_rdy = bus.cmd_rdy_UART;
      bus.resp    = RESP_ACK;
    end else begin
      bus.cmd     = cmd_q;
      bus.cmd_rdy = rdy_q;
      bus.resp    = (state_q == WAIT_H && mv_q == LAST_MV) ? RESP_ACK : RESP_POS;
    end
  end

endmodule

// File: tb/tb_tour_cmd.sv
// Directed bench for tour_cmd: pass-through table, decode table, tour sequences.
module tb_tour_cmd;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  tour_cmd_if bus();

  tour_cmd dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] cmd_uart;
    logic        rdy_uart;
    logic [15:0] exp_cmd;
    logic        exp_rdy;
  } idle_vec_t;

  typedef struct {
    logic [7:0]  move;
    logic [15:0] exp_v;
    logic [15:0] exp_h;
  } dec_vec_t;

  idle_vec_t idle_tbl[4];
  dec_vec_t  dec_tbl[11];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.start_tour = 1'b0;
    bus.move = 8'h00;
    bus.cmd_UART = 16'h0000;
    bus.cmd_rdy_UART = 1'b0;
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic start(input logic [7:0] mv);
    bus.move = mv;
    bus.start_tour = 1'b1;
    tick();
    bus.start_tour = 1'b0;
  endtask

  // Entered in the first VERT cycle; leaves the bench in WAIT_H before send_resp.
  task automatic run_leg(input logic [7:0] mv, input logic [15:0] ev, input logic [15:0] eh,
                         input bit last, input int idx);
    chk("vert_entry_rdy", {15'd0, bus.cmd_rdy}, 16'd0);
    chk("mv_indx", {11'd0, bus.mv_indx}, idx[15:0]);
    tick();
    chk("vert_rdy", {15'd0, bus.cmd_rdy}, 16'd1);
    chk("vert_cmd", bus.cmd, ev);
    chk("vert_resp", {8'd0, bus.resp}, 16'h005A);
    bus.move = ~mv;
    bus.clr_cmd_rdy = 1'b1;
    bus.send_resp = 1'b1;
    tick();
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp = 1'b0;
    chk("waitv_rdy", {15'd0, bus.cmd_rdy}, 16'd0);
    tick();
    chk("waitv_hold_rdy", {15'd0, bus.cmd_rdy}, 16'd0);
    bus.send_resp = 1'b1;
    tick();
    bus.send_resp = 1'b0;
    chk("horz_entry_rdy", {15'd0, bus.cmd_rdy}, 16'd0);
    tick();
    chk("horz_rdy", {15'd0, bus.cmd_rdy}, 16'd1);
    chk("horz_cmd", bus.cmd, eh);
    bus.clr_cmd_rdy = 1'b1;
    tick();
    bus.clr_cmd_rdy = 1'b0;
    chk("waith_rdy", {15'd0, bus.cmd_rdy}, 16'd0);
    chk("waith_resp", {8'd0, bus.resp}, last ? 16'h00A5 : 16'h005A);
    bus.move = mv;
  endtask

  task automatic send();
    bus.send_resp = 1'b1;
    tick();
    bus.send_resp = 1'b0;
  endtask

  initial begin
    idle_tbl[0] = '{16'h2001, 1'b1, 16'h2001, 1'b1};
    idle_tbl[1] = '{16'h2001, 1'b0, 16'h2001, 1'b0};
    idle_tbl[2] = '{16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    idle_tbl[3] = '{16'h5A3C, 1'b0, 16'h5A3C, 1'b0};

    dec_tbl[0]  = '{8'h01, 16'h2002, 16'h3BF1};
    dec_tbl[1]  = '{8'h02, 16'h2002, 16'h33F1};
    dec_tbl[2]  = '{8'h04, 16'h23F2, 16'h3001};
    dec_tbl[3]  = '{8'h08, 16'h23F2, 16'h37F1};
    dec_tbl[4]  = '{8'h10, 16'h27F2, 16'h33F1};
    dec_tbl[5]  = '{8'h20, 16'h27F2, 16'h3BF1};
    dec_tbl[6]  = '{8'h40, 16'h2BF2, 16'h37F1};
    dec_tbl[7]  = '{8'h80, 16'h2BF2, 16'h3001};
    dec_tbl[8]  = '{8'h0C, 16'h23F2, 16'h3001};
    dec_tbl[9]  = '{8'hFF, 16'h2002, 16'h3BF1};
    dec_tbl[10] = '{8'hC0, 16'h2BF2, 16'h37F1};

    do_reset();
    chk("reset_mv_indx", {11'd0, bus.mv_indx}, 16'd0);
    chk("reset_resp", {8'd0, bus.resp}, 16'h00A5);
    chk("reset_rdy", {15'd0, bus.cmd_rdy}, 16'd0);

    for (int i = 0; i < 4; i++) begin
      bus.cmd_UART = idle_tbl[i].cmd_uart;
      bus.cmd_rdy_UART = idle_tbl[i].rdy_uart;
      #1;
      chk("idle_cmd", bus.cmd, idle_tbl[i].exp_cmd);
      chk("idle_rdy", {15'd0, bus.cmd_rdy}, {15'd0, idle_tbl[i].exp_rdy});
      chk("idle_resp", {8'd0, bus.resp}, 16'h00A5);
    end

    for (int i = 0; i < 11; i++) begin
      do_reset();
      start(dec_tbl[i].move);
      run_leg(dec_tbl[i].move, dec_tbl[i].exp_v, dec_tbl[i].exp_h, 1'b0, 0);
    end

    // Full tour of 24 identical moves, ending back in IDLE.
    do_reset();
    start(8'h10);
    for (int i = 0; i < 24; i++) begin
      run_leg(8'h10, 16'h27F2, 16'h33F1, i == 23, i);
      send();
    end
    chk("tour_end_resp", {8'd0, bus.resp}, 16'h00A5);
    chk("tour_end_mv_indx", {11'd0, bus.mv_indx}, 16'd23);
    bus.cmd_UART = 16'h1234;
    bus.cmd_rdy_UART = 1'b1;
    #1;
    chk("tour_end_pass_cmd", bus.cmd, 16'h1234);
    chk("tour_end_pass_rdy", {15'd0, bus.cmd_rdy}, 16'd1);

    // UART valid and start_tour during WAIT_V must be ignored.
    do_reset();
    start(8'h10);
    tick();
    bus.clr_cmd_rdy = 1'b1;
    tick();
    bus.clr_cmd_rdy = 1'b0;
    bus.cmd_rdy_UART = 1'b1;
    bus.cmd_UART = 16'hBEEF;
    bus.start_tour = 1'b1;
    #1;
    chk("intf_rdy", {15'd0, bus.cmd_rdy}, 16'd0);
    chk("intf_cmd", bus.cmd, 16'h27F2);
    tick();
    bus.start_tour = 1'b0;
    chk("intf_rdy2", {15'd0, bus.cmd_rdy}, 16'd0);
    chk("intf_mv_indx", {11'd0, bus.mv_indx}, 16'd0);
    chk("intf_resp", {8'd0, bus.resp}, 16'h005A);
    send();
    tick();
    chk("intf_horz_cmd", bus.cmd, 16'h33F1);
    chk("intf_horz_rdy", {15'd0, bus.cmd_rdy}, 16'd1);

    // Reset in HORZ with mv_indx = 7.
    do_reset();
    start(8'h01);
    for (int i = 0; i < 7; i++) begin
      run_leg(8'h01, 16'h2002, 16'h3BF1, 1'b0, i);
      send();
    end
    tick();
    bus.clr_cmd_rdy = 1'b1;
    tick();
    bus.clr_cmd_rdy = 1'b0;
    send();
    tick();
    chk("pre_rst_mv_indx", {11'd0, bus.mv_indx}, 16'd7);
    chk("pre_rst_cmd", bus.cmd, 16'h3BF1);
    bus.cmd_UART = 16'h4321;
    bus.cmd_rdy_UART = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mv_indx", {11'd0, bus.mv_indx}, 16'd0);
    chk("rst_resp", {8'd0, bus.resp}, 16'h00A5);
    chk("rst_cmd", bus.cmd, 16'h4321);
    chk("rst_rdy", {15'd0, bus.cmd_rdy}, 16'd0);

    // Zero move aborts without issuing a command.
    do_reset();
    start(8'h00);
    chk("abort_entry_rdy", {15'd0, bus.cmd_rdy}, 16'd0);
    tick();
    chk("abort_rdy", {15'd0, bus.cmd_rdy}, 16'd0);
    chk("abort_resp", {8'd0, bus.resp}, 16'h00A5);
    bus.cmd_rdy_UART = 1'b1;
    bus.cmd_UART = 16'h2001;
    #1;
    chk("abort_idle_rdy", {15'd0, bus.cmd_rdy}, 16'd1);
    chk("abort_idle_cmd", bus.cmd, 16'h2001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
